// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 8-bit SISD ALU: 2-entry op queue, ALU drive and registered result/flags.
// Optional stall counter output o_stall_cnt is enabled by defining ALU_ISSUE_STALL_CNT_EN.
module alu_issue_stage #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_s1,
  input  logic [WIDTH-1:0] i_s2,
  input  logic [2:0]       i_func,
  input  logic [TAG_W-1:0] i_tag,
  output logic [WIDTH-1:0] o_alu_s1,
  output logic [WIDTH-1:0] o_alu_s2,
  output logic [2:0]       o_alu_func,
  output logic             o_alu_en,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_zero,
  output logic             o_negative,
  output logic             o_overflow
`ifdef ALU_ISSUE_STALL_CNT_EN
  ,
  output logic [15:0]      o_stall_cnt
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [2:0]       func;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t        q [2];
  op_t        head;
  op_t        new_op;
  logic [1:0] count;
  logic [1:0] tail;
  logic       push;
  logic       issue;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    o_ready    = (count < 2'd2);
    issue      = (count != 2'd0) && (!o_valid || i_ready);
    push       = i_valid && o_ready;
    tail       = count - {1'b0, issue};
    new_op     = '{s1: i_s1, s2: i_s2, func: i_func, tag: i_tag};
    head       = (count == 2'd0) ? '0 : q[0];
    o_alu_en   = issue;
    o_alu_s1   = head.s1;
    o_alu_s2   = head.s2;
    o_alu_func = head.func;
  end

  // NOTE: the queue storage is small and its cleared state is visible on the ALU
  // inputs, so it is reset like ordinary flops rather than left uninitialised.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q[0]  <= '0;
      q[1]  <= '0;
      count <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments; the later push write deliberately overrides the shift.
      if (issue) begin
        q[0] <= q[1];
        q[1] <= '0;
      end
      if (push) q[tail[0]] <= new_op;
      count <= count + {1'b0, push} - {1'b0, issue};
    end
  end

  // Output register: loads on issue, otherwise only the valid bit drops on consumption.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_result   <= '0;
      o_tag      <= '0;
      o_zero     <= 1'b0;
      o_negative <= 1'b0;
      o_overflow <= 1'b0;
    end else if (issue) begin
      o_valid    <= 1'b1;
      o_result   <= i_alu_result;
      o_tag      <= q[0].tag;
      o_zero     <= (i_alu_result == '0);
      o_negative <= i_alu_result[WIDTH-1];
      o_overflow <= i_alu_carry;
    end else if (i_ready) begin
      o_valid    <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_STALL_CNT_EN
  // Counts cycles where work is queued but writeback back-pressure blocks issue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= 16'd0;
    end else if ((count != 2'd0) && !issue && (o_stall_cnt != 16'hFFFF)) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a small behavioural ALU model in the loop.
// Define ALU_ISSUE_STALL_CNT_EN to also check the stall counter.
module tb_alu_issue_stage;
  localparam int WIDTH = 8;
  localparam int TAG_W = 3;

  logic             i_clk, i_rst_n, i_valid, o_ready, i_ready;
  logic [WIDTH-1:0] i_s1, i_s2, o_alu_s1, o_alu_s2, i_alu_result, o_result;
  logic [2:0]       i_func, o_alu_func;
  logic [TAG_W-1:0] i_tag, o_tag;
  logic             o_alu_en, i_alu_carry, o_valid, o_zero, o_negative, o_overflow;
`ifdef ALU_ISSUE_STALL_CNT_EN
  logic [15:0]      o_stall_cnt;
`endif

  alu_issue_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_s1(i_s1), .i_s2(i_s2), .i_func(i_func), .i_tag(i_tag),
    .o_alu_s1(o_alu_s1), .o_alu_s2(o_alu_s2), .o_alu_func(o_alu_func), .o_alu_en(o_alu_en),
    .i_alu_result(i_alu_result), .i_alu_carry(i_alu_carry),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_tag(o_tag),
    .o_zero(o_zero), .o_negative(o_negative), .o_overflow(o_overflow)
`ifdef ALU_ISSUE_STALL_CNT_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  // ALU stand-in: 0 add, 1 subtract (carry = borrow), 2 and, 3 xor, otherwise pass s1.
  always_comb begin
    i_alu_result = o_alu_s1;
    i_alu_carry  = 1'b0;
    case (o_alu_func)
      3'd0: {i_alu_carry, i_alu_result} = {1'b0, o_alu_s1} + {1'b0, o_alu_s2};
      3'd1: {i_alu_carry, i_alu_result} = {1'b0, o_alu_s1} - {1'b0, o_alu_s2};
      3'd2: i_alu_result = o_alu_s1 & o_alu_s2;
      3'd3: i_alu_result = o_alu_s1 ^ o_alu_s2;
      default: ;
    endcase
  end

  typedef struct {
    logic [7:0] res;
    logic [2:0] tag;
    logic       z, n, c;
    int         exp_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   en_cycles = 0;

  // Burst table: s1, s2, func, expected result and {z,n,c}.
  logic [7:0] b_s1  [10] = '{8'h01, 8'h10, 8'h10, 8'hFF, 8'h40, 8'hAA, 8'h80, 8'h12, 8'h7F, 8'hC8};
  logic [7:0] b_s2  [10] = '{8'h01, 8'h22, 8'h22, 8'hFF, 8'h40, 8'h55, 8'h80, 8'h34, 8'h7F, 8'h64};
  logic [2:0] b_fn  [10] = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [7:0] b_res [10] = '{8'h02, 8'h32, 8'h00, 8'hFE, 8'h80, 8'hFF, 8'h00, 8'h46, 8'hFE, 8'h2C};
  logic [2:0] b_znc [10] = '{3'b000, 3'b000, 3'b100, 3'b011, 3'b010, 3'b010, 3'b101, 3'b000, 3'b010, 3'b001};

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic push_op(input logic [7:0] s1, input logic [7:0] s2, input logic [2:0] func,
                         input logic [2:0] tag, input logic [7:0] res, input logic [2:0] znc,
                         input bit lat1, input bit must_ready);
    exp_t e;
    int   waits = 0;
    i_s1 = s1; i_s2 = s2; i_func = func; i_tag = tag; i_valid = 1'b1;
    @(negedge i_clk);
    if (must_ready) check("o_ready_during_burst", o_ready, 1);
    while (!o_ready && waits < 50) begin
      @(negedge i_clk);
      waits++;
    end
    if (!o_ready) begin
      check("push_timeout", o_ready, 1);
      i_valid = 1'b0;
      return;
    end
    @(posedge i_clk);
    #1;
    i_valid   = 1'b0;
    e.res     = res;
    e.tag     = tag;
    e.z       = znc[2];
    e.n       = znc[1];
    e.c       = znc[0];
    e.exp_cyc = lat1 ? cyc + 1 : -1;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int waits = 0;
    while (sb.size() != 0 && waits < 100) begin
      @(negedge i_clk);
      waits++;
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: every consumed result is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_alu_en) en_cycles++;
      if (i_rst_n && o_valid && i_ready) begin
        check("result_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("o_result", o_result, mon_e.res);
          check("o_tag", o_tag, mon_e.tag);
          check("o_zero", o_zero, mon_e.z);
          check("o_negative", o_negative, mon_e.n);
          check("o_overflow", o_overflow, mon_e.c);
          if (mon_e.exp_cyc >= 0) check("latency", cyc, mon_e.exp_cyc);
        end
      end
    end
  end

  initial begin
    int e0;
    int k0;
    int kr;
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_s1 = '0; i_s2 = '0; i_func = '0; i_tag = '0;
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_ready", o_ready, 1);
    check("rst_o_result", o_result, 0);
    check("rst_o_tag", o_tag, 0);
    check("rst_flags", {o_zero, o_negative, o_overflow}, 0);
    check("rst_o_alu_en", o_alu_en, 0);
    check("rst_alu_ops", {o_alu_s1, o_alu_s2, o_alu_func}, 0);
`ifdef ALU_ISSUE_STALL_CNT_EN
    check("rst_stall_cnt", o_stall_cnt, 0);
`endif
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Single op: one issue cycle and one valid cycle.
    e0 = en_cycles;
    push_op(8'h05, 8'h03, 3'd0, 3'd2, 8'h08, 3'b000, 1'b1, 1'b0);
    wait_drain();
    check("single_alu_en_cycles", en_cycles - e0, 1);
    check("single_valid_cleared", o_valid, 0);

    // Flag corner cases.
    push_op(8'hFF, 8'h01, 3'd0, 3'd3, 8'h00, 3'b101, 1'b1, 1'b0);
    push_op(8'h7F, 8'h01, 3'd0, 3'd4, 8'h80, 3'b010, 1'b1, 1'b0);
    push_op(8'h03, 8'h05, 3'd1, 3'd6, 8'hFE, 3'b011, 1'b1, 1'b0);
    wait_drain();

    // Writeback stall: first result held, queue fills, then drains in order.
    i_ready = 1'b0;
    push_op(8'h10, 8'h20, 3'd0, 3'd1, 8'h30, 3'b000, 1'b0, 1'b0);
    k0 = cyc;
    push_op(8'hF0, 8'h20, 3'd0, 3'd3, 8'h10, 3'b001, 1'b0, 1'b0);
    push_op(8'h80, 8'h80, 3'd0, 3'd5, 8'h00, 3'b101, 1'b0, 1'b0);
    @(negedge i_clk);
    check("stall_o_ready_full", o_ready, 0);
    check("stall_o_valid", o_valid, 1);
    repeat (3) begin
      @(negedge i_clk);
      check("stall_hold_result", o_result, 8'h30);
      check("stall_hold_tag", o_tag, 3'd1);
      check("stall_no_issue", o_alu_en, 0);
    end
    @(posedge i_clk);
    #1;
    kr = cyc;
    i_ready = 1'b1;
    wait_drain();
`ifdef ALU_ISSUE_STALL_CNT_EN
    check("stall_cnt", o_stall_cnt, kr - k0 - 1);
`else
    check("stall_window", kr - k0, 6);
`endif

    // Back-to-back burst of ten ops at full rate.
    e0 = en_cycles;
    for (int i = 0; i < 10; i++) begin
      push_op(b_s1[i], b_s2[i], b_fn[i], 3'(i), b_res[i], b_znc[i], 1'b1, 1'b1);
    end
    wait_drain();
    check("burst_alu_en_cycles", en_cycles - e0, 10);

    // Reset with a full queue and a held result.
    i_ready = 1'b0;
    push_op(8'h01, 8'h02, 3'd0, 3'd1, 8'h03, 3'b000, 1'b0, 1'b0);
    push_op(8'h04, 8'h05, 3'd0, 3'd2, 8'h09, 3'b000, 1'b0, 1'b0);
    push_op(8'h06, 8'h07, 3'd0, 3'd3, 8'h0D, 3'b000, 1'b0, 1'b0);
    @(negedge i_clk);
    check("pre_reset_full", o_ready, 0);
    check("pre_reset_valid", o_valid, 1);
    #2 i_rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o_ready", o_ready, 1);
    check("midrst_o_result", o_result, 0);
    check("midrst_o_tag", o_tag, 0);
    check("midrst_flags", {o_zero, o_negative, o_overflow}, 0);
    check("midrst_alu", {o_alu_en, o_alu_s1, o_alu_s2, o_alu_func}, 0);
`ifdef ALU_ISSUE_STALL_CNT_EN
    check("midrst_stall_cnt", o_stall_cnt, 0);
`endif
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    i_rst_n = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      check("post_reset_no_stale", o_valid, 0);
    end
    @(posedge i_clk);
    #1;
    push_op(8'h33, 8'h44, 3'd0, 3'd7, 8'h77, 3'b000, 1'b1, 1'b1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the SISD 8-bit ALU.
- Accepts decoded operations (two operands, function code, destination tag) from decode over a valid/ready handshake and buffers them in a 2-entry queue.
- Drives the combinational ALU inputs and registers the ALU result with derived flags into an output register for writeback, which has its own valid/ready handshake.
- Decouples decode from writeback stalls while sustaining 1 op/cycle.

Parameters:
- WIDTH, 8, operand/result width; must match ALU SIZE.
- TAG_W, 3, destination-register tag width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  decode presents an op.
- o_ready  out  1  stage can accept an op this cycle.
- i_s1  in  WIDTH  operand 1.
- i_s2  in  WIDTH  operand 2.
- i_func  in  3  ALU function code, passed through unchanged.
- i_tag  in  TAG_W  destination tag.
- o_alu_s1  out  WIDTH  to ALU i_s1.
- o_alu_s2  out  WIDTH  to ALU i_s2.
- o_alu_func  out  3  to ALU i_func.
- o_alu_en  out  1  to ALU i_en; high only in an issue cycle.
- i_alu_result  in  WIDTH  from ALU o_result (combinational).
- i_alu_carry  in  1  from ALU o_overflow.
- o_valid  out  1  result register holds an unconsumed result.
- i_ready  in  1  writeback accepts the result.
- o_result  out  WIDTH  registered result.
- o_tag  out  TAG_W  registered destination tag.
- o_zero  out  1  registered: result == 0.
- o_negative  out  1  registered: result[WIDTH-1].
- o_overflow  out  1  registered: ALU carry.

Behaviour:
- Reset (i_rst_n low, asynchronous): queue count=0; o_valid, o_result, o_tag, o_zero, o_negative, o_overflow = 0; queue entries cleared to 0. o_ready=1 during and after reset. Reset mid-operation discards all queued and registered ops; no partial result is ever presented.
- Queue: 2-entry FIFO, head at entry 0. o_ready = (count < 2), decoded from registered count only, with no combinational path from i_ready.
- Push: i_valid && o_ready at an edge writes {s1,s2,func,tag} at the tail.
- Issue condition: issue = (count > 0) && (!o_valid || i_ready).
- In an issue cycle: o_alu_en=1; o_alu_s1/s2/func = head entry. At the edge, the output register loads i_alu_result, i_tag(head), zero/negative/carry flags, sets o_valid=1, and pops the head.
- When no issue: o_alu_en=0; o_alu_s1/s2/func still show head entry contents (zeros if empty), with no other change.
- Writeback: o_valid && i_ready at an edge consumes the result. If no issue occurs at that edge, o_valid clears to 0; o_result/flags/tag hold their old values.
- Hold: o_valid && !i_ready means o_result, o_tag and the flags are stable, and no issue occurs.
- Simultaneous push+pop: count unchanged; the new op goes behind the remaining entry. At count=1, the pushed op becomes head after the edge. At count=2, push is impossible (o_ready=0).
- Latency: op accepted at edge k is issued in cycle k→k+1 and is visible on o_valid after edge k+1. Back-to-back throughput is 1 op/cycle with i_ready=1.
- Ordering: strict FIFO; results leave in acceptance order.
- Arithmetic: none internal. Flags are derived from i_alu_result at WIDTH bits; carry is passed through untouched.

Optional Feature:
- Macro ALU_ISSUE_STALL_CNT_EN.
- Defined: adds output o_stall_cnt (16-bit).
  - Increments on every cycle where count>0 and issue=0, i.e. back-pressure from writeback.
  - Saturates at 0xFFFF.
  - Reset to 0 by i_rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then a single op s1=0x05, s2=0x03, func=0, tag=2, i_ready=1 → o_alu_en high one cycle; o_valid high for one cycle with o_result=0x08, o_tag=2, zero=0, neg=0, ovf=0.
- Op s1=0xFF, s2=0x01 → o_result=0x00, zero=1, ovf=1. Op s1=0x7F, s2=0x01 → o_result=0x80, neg=1, ovf=0.
- i_ready=0, push 3 ops → first result held stable on outputs, o_ready=0 after 2 queued; raise i_ready → 3 results in order, one per cycle; stall counter (if enabled) = number of blocked cycles.
- Continuous i_valid, i_ready=1, 10 ops → 10 results on 10 consecutive cycles, 1-cycle latency, o_ready never drops.
- Assert i_rst_n=0 mid-stream with count=2 and o_valid=1 → all outputs 0 immediately, o_ready=1; after release no stale result appears.
